// File: rtl/prog_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
// The master side is the loader itself; the slave side is the environment
// that feeds bytes and owns the instruction memory.
interface prog_loader_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;

  modport master (
    input  rx_data, rx_valid,
    output rx_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    output rx_data, rx_valid,
    input  rx_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/prog_loader.sv
// Serial program loader: parses a framed byte stream (A5, count, start PC,
// big-endian words, checksum), writes each word into instruction memory and
// releases the core with the start PC once the checksum matches.
module prog_loader #(
  parameter int unsigned ADDR_W    = 8,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst_n,
  prog_loader_if.master bus,
  output logic         core_run,
  output logic [31:0]  start_pc,
  output logic         err,
  output logic [15:0]  words_loaded
);

  typedef enum logic [2:0] {
    IDLE, CNT, PC, DATA, CSUM, DONE, ERR
  } state_t;

  localparam logic [7:0]  HEADER    = 8'hA5;
  localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_W;

  state_t      state;
  logic [1:0]  byte_cnt;
  logic [15:0] count;
  logic [23:0] sh;
  logic [31:0] pc_reg;
  logic [7:0]  sum;
  logic        accept;
  logic [7:0]  b;

  // Byte handshake qualifier.
  always_comb begin
    accept = bus.rx_valid & bus.rx_ready;
    b      = bus.rx_data;
  end

  // Frame parser FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      byte_cnt       <= '0;
      count          <= '0;
      sh             <= '0;
      pc_reg         <= '0;
      sum            <= '0;
      bus.rx_ready   <= 1'b0;
      bus.imem_we    <= 1'b0;
      bus.imem_addr  <= '0;
      bus.imem_wdata <= '0;
      core_run       <= 1'b0;
      start_pc       <= '0;
      err            <= 1'b0;
      words_loaded   <= '0;
    end else begin
      bus.rx_ready <= 1'b1;
      bus.imem_we  <= 1'b0;
      if (accept) begin
        unique case (state)
          IDLE, DONE, ERR: begin
            if (b == HEADER) begin
              state        <= CNT;
              byte_cnt     <= '0;
              sum          <= '0;
              words_loaded <= '0;
              err          <= 1'b0;
              core_run     <= 1'b0;
            end
          end
          CNT: begin
            sum <= sum + b;
            if (byte_cnt == 2'd0) begin
              count[15:8] <= b;
              byte_cnt    <= 2'd1;
            end else begin
              count[7:0] <= b;
              byte_cnt   <= '0;
              if ({1'b0, count[15:8], b} > MAX_WORDS) begin
                state <= ERR;
                err   <= 1'b1;
              end else begin
                state <= PC;
              end
            end
          end
          PC: begin
            sum      <= sum + b;
            sh       <= {sh[15:0], b};
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              pc_reg <= {sh, b};
              state  <= (count == 16'd0) ? CSUM : DATA;
            end
          end
          DATA: begin
            sum      <= sum + b;
            sh       <= {sh[15:0], b};
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              bus.imem_we    <= 1'b1;
              bus.imem_wdata <= {sh, b};
              bus.imem_addr  <= BASE_ADDR + {14'b0, words_loaded, 2'b00};
              words_loaded   <= words_loaded + 16'd1;
              if ((words_loaded + 16'd1) == count) state <= CSUM;
            end
          end
          CSUM: begin
            if (b == sum) begin
              state    <= DONE;
              core_run <= 1'b1;
              start_pc <= pc_reg;
            end else begin
              state <= ERR;
              err   <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: per-byte vector table for the nominal
// frame, scoreboard of expected instruction-memory writes, and hand-written
// sequences for error, gap, reset and reload cases.
module tb_prog_loader;

  logic clk;
  logic rst_n;
  logic        core_run;
  logic [31:0] start_pc;
  logic        err;
  logic [15:0] words_loaded;

  prog_loader_if bus();

  prog_loader #(.ADDR_W(8), .BASE_ADDR(32'h0000_0000)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .core_run     (core_run),
    .start_pc     (start_pc),
    .err          (err),
    .words_loaded (words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic [7:0]  b;
    logic        we;
    logic        run;
    logic        er;
    logic [15:0] words;
  } vec_t;

  wr_t  exp_q[$];
  vec_t tbl[16];
  logic [7:0] f1[16];
  logic [7:0] f3[8];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic mon();
    wr_t w;
    if (bus.imem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL extra_write actual addr=%h data=%h required=none",
                 bus.imem_addr, bus.imem_wdata);
      end else begin
        w = exp_q.pop_front();
        check("wr_addr", bus.imem_addr, w.addr);
        check("wr_data", bus.imem_wdata, w.data);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    mon();
  endtask

  task automatic idle(input int n);
    bus.rx_valid = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic send_byte(input logic [7:0] v);
    int n = 0;
    while (bus.rx_ready !== 1'b1 && n < 10) begin
      step();
      n++;
    end
    if (n == 10) check("rx_ready_timeout", {31'b0, bus.rx_ready}, 32'd1);
    bus.rx_data  = v;
    bus.rx_valid = 1'b1;
    step();
    bus.rx_valid = 1'b0;
  endtask

  task automatic push_f1();
    exp_q.push_back({32'h0000_0000, 32'h2008_0005});
    exp_q.push_back({32'h0000_0004, 32'h2009_000A});
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_rx_ready"}, {31'b0, bus.rx_ready}, 32'd0);
    check({tag, "_we"},       {31'b0, bus.imem_we}, 32'd0);
    check({tag, "_addr"},     bus.imem_addr, 32'd0);
    check({tag, "_wdata"},    bus.imem_wdata, 32'd0);
    check({tag, "_run"},      {31'b0, core_run}, 32'd0);
    check({tag, "_pc"},       start_pc, 32'd0);
    check({tag, "_err"},      {31'b0, err}, 32'd0);
    check({tag, "_words"},    {16'b0, words_loaded}, 32'd0);
  endtask

  task automatic check_f1_done(input string tag);
    check({tag, "_run"},   {31'b0, core_run}, 32'd1);
    check({tag, "_pc"},    start_pc, 32'h0000_0040);
    check({tag, "_err"},   {31'b0, err}, 32'd0);
    check({tag, "_words"}, {16'b0, words_loaded}, 32'd2);
    check({tag, "_pending"}, exp_q.size(), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    f1 = '{8'hA5, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h40, 8'h20,
           8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h0A, 8'hA2};
    f3 = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h10, 8'h10};

    //            byte   we    run   err   words
    tbl[0]  = '{8'hA5, 1'b0, 1'b0, 1'b0, 16'd0};
    tbl[1]  = '{8'h00, 1'b0, 1'b0, 1'b0, 16'd0};
    tbl[2]  = '{8'h02, 1'b0, 1'b0, 1'b0, 16'd0};
    tbl[3]  = '{8'h00, 1'b0, 1'b0, 1'b0, 16'd0};
    tbl[4]  = '{8'h00, 1'b0, 1'b0, 1'b0, 16'd0};
    tbl[5]  = '{8'h00, 1'b0, 1'b0, 1'b0, 16'd0};
    tbl[6]  = '{8'h40, 1'b0, 1'b0, 1'b0, 16'd0};
    tbl[7]  = '{8'h20, 1'b0, 1'b0, 1'b0, 16'd0};
    tbl[8]  = '{8'h08, 1'b0, 1'b0, 1'b0, 16'd0};
    tbl[9]  = '{8'h00, 1'b0, 1'b0, 1'b0, 16'd0};
    tbl[10] = '{8'h05, 1'b1, 1'b0, 1'b0, 16'd1};
    tbl[11] = '{8'h20, 1'b0, 1'b0, 1'b0, 16'd1};
    tbl[12] = '{8'h09, 1'b0, 1'b0, 1'b0, 16'd1};
    tbl[13] = '{8'h00, 1'b0, 1'b0, 1'b0, 16'd1};
    tbl[14] = '{8'h0A, 1'b1, 1'b0, 1'b0, 16'd2};
    tbl[15] = '{8'hA2, 1'b0, 1'b1, 1'b0, 16'd2};

    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    rst_n = 1'b0;
    step();
    step();
    check_zero("reset");
    rst_n = 1'b1;
    step();
    check("ready_after_reset", {31'b0, bus.rx_ready}, 32'd1);

    // Nominal frame, checked byte by byte.
    push_f1();
    for (int i = 0; i < 16; i++) begin
      send_byte(tbl[i].b);
      check($sformatf("v%0d_we", i),    {31'b0, bus.imem_we}, {31'b0, tbl[i].we});
      check($sformatf("v%0d_run", i),   {31'b0, core_run},    {31'b0, tbl[i].run});
      check($sformatf("v%0d_err", i),   {31'b0, err},         {31'b0, tbl[i].er});
      check($sformatf("v%0d_words", i), {16'b0, words_loaded}, {16'b0, tbl[i].words});
    end
    idle(2);
    check_f1_done("f1");

    // Reload while running: header drops core_run, new frame sets new PC.
    send_byte(8'hA5);
    check("reload_run_drop", {31'b0, core_run}, 32'd0);
    check("reload_words_clr", {16'b0, words_loaded}, 32'd0);
    for (int i = 1; i < 8; i++) send_byte(f3[i]);
    check("reload_run", {31'b0, core_run}, 32'd1);
    check("reload_pc", start_pc, 32'h0000_0010);

    // Bad checksum: writes still happen, err set, core held.
    push_f1();
    for (int i = 0; i < 15; i++) send_byte(f1[i]);
    send_byte(8'hA3);
    check("badcs_err", {31'b0, err}, 32'd1);
    check("badcs_run", {31'b0, core_run}, 32'd0);
    check("badcs_words", {16'b0, words_loaded}, 32'd2);
    check("badcs_pending", exp_q.size(), 32'd0);

    // N = 256 is the largest legal count.
    send_byte(8'hA5);
    check("hdr_clears_err", {31'b0, err}, 32'd0);
    send_byte(8'h01);
    send_byte(8'h00);
    check("n256_err", {31'b0, err}, 32'd0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();

    // N = 257 is oversized; following bytes produce no writes.
    send_byte(8'hA5);
    send_byte(8'h01);
    check("n257_err_early", {31'b0, err}, 32'd0);
    send_byte(8'h01);
    check("n257_err", {31'b0, err}, 32'd1);
    for (int i = 7; i < 15; i++) send_byte(f1[i]);
    check("n257_words", {16'b0, words_loaded}, 32'd0);
    check("n257_err_hold", {31'b0, err}, 32'd1);
    check("n257_run", {31'b0, core_run}, 32'd0);

    // Nominal frame with random valid gaps.
    push_f1();
    for (int i = 0; i < 16; i++) begin
      idle($urandom_range(0, 3));
      send_byte(f1[i]);
    end
    idle(3);
    check_f1_done("gaps");

    // Reset after two data bytes, then a clean frame.
    for (int i = 0; i < 9; i++) send_byte(f1[i]);
    rst_n = 1'b0;
    #1;
    check_zero("midreset");
    step();
    step();
    step();
    rst_n = 1'b1;
    step();
    push_f1();
    for (int i = 0; i < 16; i++) send_byte(f1[i]);
    idle(1);
    check_f1_done("postreset");

    // Leading junk then N = 0 frame.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h5A);
    check("junk_run", {31'b0, core_run}, 32'd0);
    check("junk_words", {16'b0, words_loaded}, 32'd0);
    for (int i = 0; i < 8; i++) send_byte(f3[i]);
    idle(2);
    check("n0_run", {31'b0, core_run}, 32'd1);
    check("n0_pc", start_pc, 32'h0000_0010);
    check("n0_words", {16'b0, words_loaded}, 32'd0);
    check("n0_err", {31'b0, err}, 32'd0);
    check("n0_pending", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
# prog_loader

Serial program loader that sits upstream of the pipelined MIPS core. It receives a framed byte stream and assembles big-endian 32-bit instruction words. Each word is written into instruction memory through a dedicated write port. After a valid checksum it releases the core with the start PC that drives the core's PC initial value. A failed or oversized frame leaves the core held and raises `err`.

## Interface
Parameters:
- `ADDR_W`, 8: word-address bits of instruction memory; capacity = 2^ADDR_W words.
- `BASE_ADDR`, 32'h0000_0000: byte address of the first loaded word.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `rx_data`  in  8  incoming stream byte.
- `rx_valid`  in  1  `rx_data` valid this cycle.
- `rx_ready`  out  1  loader accepts a byte this cycle.
- `imem_we`  out  1  one-cycle instruction-memory write strobe.
- `imem_addr`  out  32  byte address of the write.
- `imem_wdata`  out  32  instruction word written.
- `core_run`  out  1  level; core may fetch from `start_pc`.
- `start_pc`  out  32  PC value for the core; valid while `core_run`=1.
- `err`  out  1  sticky frame error.
- `words_loaded`  out  16  words written in the current frame.

## Operation
- A byte is accepted when `rx_valid` and `rx_ready` are both 1. `rx_ready` is 0 during reset and 1 in every state otherwise.
- The frame has the following fields, all multi-byte fields MSB first:
  - header 0xA5;
  - 2-byte word count N;
  - 4-byte start PC;
  - N×4 data bytes;
  - 1-byte checksum equal to the 8-bit modulo-256 sum of every byte after the header.
- States are IDLE, CNT, PC, DATA, CSUM, DONE, ERR.
  - IDLE: discards non-0xA5 bytes. On 0xA5 it goes to CNT, clears the sum, clears `words_loaded` and clears `err`.
  - CNT: collects 2 bytes. If N > 2^ADDR_W after the second byte, it goes to ERR.
  - PC: collects 4 bytes. It then goes to DATA, or to CSUM when N=0.
  - DATA: shifts bytes into a 32-bit assembly register. Each 4th byte of a word triggers a write. After word N-1 it goes to CSUM.
  - CSUM: compares the received byte with the running sum. On a match it goes to DONE, otherwise to ERR.
  - DONE: asserts `core_run`. Bytes other than 0xA5 are discarded. A 0xA5 byte deasserts `core_run` and starts a new frame, i.e. a reload.
  - ERR: asserts `err`. A 0xA5 byte starts a new frame; other bytes are discarded.
- Write address for word i is BASE_ADDR + 4·i. The adder is 32 bits wide and wraps.
- Writes already issued are not rolled back on error.
- `rx_valid` gaps are legal in any state. No state advances without an accepted byte.

## Timing
- Reset values:
  - `rx_ready`=0, `imem_we`=0, `imem_addr`=0, `imem_wdata`=0;
  - `core_run`=0, `start_pc`=0, `err`=0, `words_loaded`=0;
  - state = IDLE.
- Throughput is one byte per cycle.
- Write latency: `imem_we` is high for exactly the cycle after the 4th byte of a word is accepted. `imem_addr` and `imem_wdata` are valid in that cycle and hold afterwards. `words_loaded` increments in the same cycle.
- `core_run` and `start_pc` update in the cycle after the accepted checksum byte. `err` rises in that same cycle on a checksum mismatch.
- An oversized N sets `err` in the cycle after the second count byte is accepted.
- A reload header deasserts `core_run` in the cycle after it is accepted.
- Reset mid-frame clears all outputs immediately. No pending `imem_we` is emitted after reset.

## Test plan
- Correct frame with ADDR_W=8:
  - stimulus: A5 00 02 00 00 00 40 20 08 00 05 20 09 00 0A A2;
  - required response: `imem_we` pulses with addr 0x0/data 0x20080005, then addr 0x4/data 0x2009000A;
  - `words_loaded`=2, `core_run`=1, `start_pc`=0x00000040, `err`=0.
- Same frame with checksum byte A3 → both writes occur, `err`=1, `core_run`=0.
- Leading bytes 00 FF 5A, then a valid N=0 frame:
  - stimulus: A5 00 00 00 00 00 10 10;
  - required response: no writes, `core_run`=1, `start_pc`=0x10.
- Count 01 01 (257 > 256) → `err`=1 one cycle after the second count byte; subsequent bytes produce no writes until the next 0xA5.
- Frame from the first scenario with random `rx_valid` gaps → identical writes and results, with no extra strobes.
- Reset asserted after 2 data bytes → all outputs 0 and no write strobe; a full frame afterwards behaves as in the first scenario.
- Reload while `core_run`=1: a new valid frame → `core_run` drops after its header and re-asserts with the new `start_pc`.
